// File: rtl/bram_if_multi.sv
// Schedule-driven sequencer for NUM_PORTS data-buffer BRAM ports with a Start/Done/Busy host handshake.
// Define BRAMIF_BYTE_ADDR_EN for byte-granular Port_Addr; otherwise Port_Addr carries word addresses.
module bram_if_multi #(
  parameter int NUM_PORTS   = 2,
  parameter int SYS_DWIDTH  = 32,
  parameter int BYTE_LEN    = 4,
  parameter int DBUF_AWIDTH = 13,
  parameter int ABUF_AWIDTH = 12,
  parameter int ABUF_DWIDTH = DBUF_AWIDTH + 5,
  parameter int CPW         = 1
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             Start,
  output logic                             Done,
  output logic                             Busy,
  output logic                             Err,
  output logic [15:0]                      Item_Cnt,
  input  logic                             Cfg_Wen,
  input  logic [CPW-1:0]                   Cfg_Port,
  input  logic [ABUF_AWIDTH-1:0]           Cfg_Addr,
  input  logic [ABUF_DWIDTH-1:0]           Cfg_Data,
  output logic [NUM_PORTS-1:0]             Port_En,
  output logic [NUM_PORTS*BYTE_LEN-1:0]    Port_Wen,
  output logic [NUM_PORTS*SYS_DWIDTH-1:0]  Port_Addr,
  output logic [NUM_PORTS*SYS_DWIDTH-1:0]  Port_Data_To_Bram,
  input  logic [NUM_PORTS*SYS_DWIDTH-1:0]  Port_Data_From_Bram,
  output logic [NUM_PORTS*SYS_DWIDTH-1:0]  Port_Data_To_CGRA,
  input  logic [NUM_PORTS*SYS_DWIDTH-1:0]  Port_Data_From_CGRA
);

  localparam int D     = DBUF_AWIDTH;
  localparam int DEPTH = 1 << ABUF_AWIDTH;
`ifdef BRAMIF_BYTE_ADDR_EN
  localparam int BSHIFT = $clog2(BYTE_LEN);
`endif
  localparam logic [ABUF_AWIDTH-1:0] CNT_MAX = '1;
  localparam logic [2:0] ST_BUSY  = 3'b100;
  localparam logic [2:0] ST_ITEM  = 3'b010;
  localparam logic [2:0] ST_KDONE = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;
  state_t state;

  logic                         start_q;
  logic                         rise, fall;
  logic [ABUF_AWIDTH-1:0]       cnt;
  logic [ABUF_DWIDTH-1:0]       mem  [NUM_PORTS][DEPTH];
  logic [ABUF_DWIDTH-1:0]       rd_q [NUM_PORTS];
  logic                         vld1, vld2;
  logic [2:0]                   status_q;
  logic                         kdone, rsvd, item, overrun;
  logic [NUM_PORTS-1:0]         en_nxt;
  logic [NUM_PORTS*BYTE_LEN-1:0]   wen_nxt;
  logic [NUM_PORTS*SYS_DWIDTH-1:0] addr_nxt;

  assign rise = Start & ~start_q;
  assign fall = ~Start & start_q;

  assign Port_Data_To_Bram = Port_Data_From_CGRA;
  assign Port_Data_To_CGRA = Port_Data_From_Bram;

  // Control memories: host writes only while idle; reads are always registered off the schedule counter.
  always_ff @(posedge Clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (Cfg_Wen && state == S_IDLE && Cfg_Port == CPW'(p))
        mem[p][Cfg_Addr] <= Cfg_Data;
      rd_q[p] <= mem[p][cnt];
    end
  end

  always_comb begin
    en_nxt   = '0;
    wen_nxt  = '0;
    addr_nxt = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      en_nxt[p] = rd_q[p][D+4];
      wen_nxt[p*BYTE_LEN +: BYTE_LEN] = {BYTE_LEN{rd_q[p][D+3]}};
`ifdef BRAMIF_BYTE_ADDR_EN
      addr_nxt[p*SYS_DWIDTH +: SYS_DWIDTH] = SYS_DWIDTH'(rd_q[p][D-1:0]) << BSHIFT;
`else
      addr_nxt[p*SYS_DWIDTH +: SYS_DWIDTH] = SYS_DWIDTH'(rd_q[p][D-1:0]);
`endif
    end
  end

  assign kdone   = vld2 && (status_q == ST_KDONE);
  assign item    = vld2 && (status_q == ST_ITEM);
  assign rsvd    = vld2 && !(status_q == ST_BUSY || status_q == ST_ITEM || status_q == ST_KDONE);
  assign overrun = (cnt == CNT_MAX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
      Err       <= 1'b0;
      Item_Cnt  <= '0;
      cnt       <= '0;
      vld1      <= 1'b0;
      vld2      <= 1'b0;
      status_q  <= '0;
      Port_En   <= '0;
      Port_Wen  <= '0;
      Port_Addr <= '0;
    end else begin
      start_q <= Start;
      case (state)
        S_IDLE: begin
          if (rise) begin
            state    <= S_RUN;
            cnt      <= '0;
            Item_Cnt <= '0;
            Err      <= 1'b0;
            Busy     <= 1'b1;
          end
        end
        S_RUN: begin
          cnt  <= cnt + 1'b1;
          vld1 <= 1'b1;
          vld2 <= vld1;
          if (vld1) begin
            Port_En   <= en_nxt;
            Port_Wen  <= wen_nxt;
            Port_Addr <= addr_nxt;
            status_q  <= rd_q[0][D+2:D];
          end else begin
            Port_En   <= '0;
            Port_Wen  <= '0;
            Port_Addr <= '0;
          end
          // Any exit drops the two words already in the pipeline behind the terminating one.
          if (fall || kdone || rsvd || overrun) begin
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            Port_En   <= '0;
            Port_Wen  <= '0;
            Port_Addr <= '0;
            Busy      <= 1'b0;
            if (fall) begin
              state <= S_IDLE;
            end else if (kdone) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state <= S_ERR;
              Err   <= 1'b1;
            end
          end else if (item && Item_Cnt != 16'hFFFF) begin
            Item_Cnt <= Item_Cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (fall) begin
            state <= S_IDLE;
            Done  <= 1'b0;
          end
        end
        S_ERR: begin
          if (fall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_if_multi.sv
// Scoreboard bench for bram_if_multi: a cycle-level schedule model fills expectation queues, a negedge monitor checks them.
module tb_bram_if_multi;
  localparam int NP    = 4;
  localparam int SW    = 32;
  localparam int BL    = 4;
  localparam int DA    = 13;
  localparam int AA    = 4;
  localparam int AD    = DA + 5;
  localparam int CP    = 2;
  localparam int DEPTH = 1 << AA;
  localparam int MAXC  = DEPTH - 1;

  logic Clk = 1'b0, Rst = 1'b1, Start = 1'b0;
  logic Done, Busy, Err;
  logic [15:0] Item_Cnt;
  logic Cfg_Wen = 1'b0;
  logic [CP-1:0] Cfg_Port = '0;
  logic [AA-1:0] Cfg_Addr = '0;
  logic [AD-1:0] Cfg_Data = '0;
  logic [NP-1:0] Port_En;
  logic [NP*BL-1:0] Port_Wen;
  logic [NP*SW-1:0] Port_Addr, Port_Data_To_Bram, Port_Data_To_CGRA;
  logic [NP*SW-1:0] Port_Data_From_Bram = '0, Port_Data_From_CGRA = '0;

  bram_if_multi #(.NUM_PORTS(NP), .SYS_DWIDTH(SW), .BYTE_LEN(BL), .DBUF_AWIDTH(DA),
                  .ABUF_AWIDTH(AA), .CPW(CP)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Done(Done), .Busy(Busy), .Err(Err),
    .Item_Cnt(Item_Cnt), .Cfg_Wen(Cfg_Wen), .Cfg_Port(Cfg_Port), .Cfg_Addr(Cfg_Addr),
    .Cfg_Data(Cfg_Data), .Port_En(Port_En), .Port_Wen(Port_Wen), .Port_Addr(Port_Addr),
    .Port_Data_To_Bram(Port_Data_To_Bram), .Port_Data_From_Bram(Port_Data_From_Bram),
    .Port_Data_To_CGRA(Port_Data_To_CGRA), .Port_Data_From_CGRA(Port_Data_From_CGRA)
  );

  always #5 Clk = ~Clk;

  typedef struct { int n; logic [NP-1:0] en; logic [NP*BL-1:0] wen; logic [NP*SW-1:0] addr; } acc_t;
  typedef struct { int n; logic done; logic err; logic [15:0] items; } term_t;

  acc_t  acc_q[$];
  term_t term_q[$];
  logic [AD-1:0] mm [NP][DEPTH];
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, term_cnt = 0;
  bit mon_en = 0, exp_done = 0, exp_err = 0;
  logic busy_prev = 1'b0;
  int mon_n;
  acc_t mon_a;
  term_t mon_t;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: Port_En != 0 is an issued access, Busy edges delimit a kernel.
  always @(negedge Clk) begin
    if (mon_en) begin
      mon_n = cyc - start_cyc;
      if (Busy && !busy_prev) begin
        chk("start_cycle", mon_n, 0);
        chk("start_item_clr", Item_Cnt, 0);
        chk("start_err_clr", Err, 0);
        chk("start_done_clr", Done, 0);
      end
      if (!Busy && busy_prev) begin
        checks++;
        if (term_q.size() == 0) begin
          errors++;
          $display("FAIL term_unexpected: Busy fell at cycle %0d with no termination expected", mon_n);
        end else begin
          mon_t = term_q.pop_front();
          chk("term_cycle", mon_n, mon_t.n);
          chk("term_done", Done, mon_t.done);
          chk("term_err", Err, mon_t.err);
          chk("term_items", Item_Cnt, mon_t.items);
        end
        term_cnt++;
      end
      if (Port_En != '0) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL acc_unexpected: cycle %0d en %0h addr %0h, required no access", mon_n, Port_En, Port_Addr);
        end else begin
          mon_a = acc_q.pop_front();
          chk("acc_cycle", mon_n, mon_a.n);
          chk("acc_en", Port_En, mon_a.en);
          chk("acc_wen", Port_Wen, mon_a.wen);
          chk("acc_addr", Port_Addr, mon_a.addr);
        end
      end else if (!Busy) begin
        chk("idle_wen", Port_Wen, 0);
        chk("idle_addr", Port_Addr, 0);
      end
      busy_prev = Busy;
    end
  end

  function automatic logic [AD-1:0] rw(input logic [2:0] st);
    logic [AD-1:0] w;
    w = AD'($urandom);
    w[DA+2:DA] = st;
    return w;
  endfunction

  function automatic logic [2:0] rsv_code();
    logic [2:0] s;
    do s = 3'($urandom); while (s == 3'b100 || s == 3'b010 || s == 3'b001);
    return s;
  endfunction

  task automatic fill_random();
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < DEPTH; a++) mm[p][a] = AD'($urandom);
  endtask

  // term: 0 ends with kernel-done, 1 ends with a reserved code, 2 never terminates
  task automatic sched0(input int len, input int term);
    for (int k = 0; k < DEPTH; k++)
      if (term == 2 || k < len - 1) mm[0][k] = rw($urandom_range(0, 1) != 0 ? 3'b100 : 3'b010);
    if (term == 0) mm[0][len-1] = rw(3'b001);
    if (term == 1) mm[0][len-1] = rw(rsv_code());
  endtask

  task automatic load_mem();
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < DEPTH; a++) begin
        @(posedge Clk); #1;
        Cfg_Wen = 1'b1; Cfg_Port = CP'(p); Cfg_Addr = AA'(a); Cfg_Data = mm[p][a];
      end
    @(posedge Clk); #1;
    Cfg_Wen = 1'b0;
  endtask

  // Cycle n counts clocks after the launching edge; word k is presented at cycle k+2 and cnt equals n.
  task automatic build_expect(input int abort_at, input bit by_rst);
    int items;
    acc_t a;
    term_t t;
    logic [2:0] st;
    logic [AD-1:0] w;
    bit pres;
    items = 0; exp_done = 0; exp_err = 0;
    for (int n = 0; n < 4 * DEPTH; n++) begin
      pres = (n >= 2);
      st = '0;
      if (pres) begin
        a.n = n; a.en = '0; a.wen = '0; a.addr = '0;
        for (int p = 0; p < NP; p++) begin
          w = mm[p][n-2];
          a.en[p] = w[DA+4];
          a.wen[p*BL +: BL] = {BL{w[DA+3]}};
`ifdef BRAMIF_BYTE_ADDR_EN
          a.addr[p*SW +: SW] = SW'(w[DA-1:0]) * BL;
`else
          a.addr[p*SW +: SW] = SW'(w[DA-1:0]);
`endif
        end
        if (a.en != '0) acc_q.push_back(a);
        st = mm[0][n-2][DA+2:DA];
      end
      t.n = n + 1; t.done = 1'b0; t.err = 1'b0; t.items = 16'(items);
      if (n == abort_at) begin
        if (by_rst) t.items = '0;
        term_q.push_back(t);
        break;
      end
      if (pres && st == 3'b001) begin
        t.done = 1'b1; exp_done = 1; term_q.push_back(t);
        break;
      end
      if ((pres && st != 3'b100 && st != 3'b010) || n == MAXC) begin
        t.err = 1'b1; exp_err = 1; term_q.push_back(t);
        break;
      end
      if (pres && st == 3'b010 && items < 65535) items++;
    end
  endtask

  task automatic run(input int abort_at, input bit use_rst, input bit cfg_in_run);
    int tc0;
    logic [NP*SW-1:0] cg, br;
    build_expect(abort_at, use_rst);
    for (int p = 0; p < NP; p++) begin
      cg[p*SW +: SW] = $urandom;
      br[p*SW +: SW] = $urandom;
    end
    cg[SW +: SW] = 32'hDEADBEEF;
    @(posedge Clk); #1;
    Port_Data_From_CGRA = cg; Port_Data_From_Bram = br;
    Start = 1'b1;
    start_cyc = cyc + 1;
    tc0 = term_cnt;
    #1;
    chk("to_bram", Port_Data_To_Bram, cg);
    chk("to_bram_p1", Port_Data_To_Bram[SW +: SW], 32'hDEADBEEF);
    chk("to_cgra", Port_Data_To_CGRA, br);
    if (cfg_in_run) begin
      repeat (4) begin
        @(posedge Clk); #1;
        Cfg_Wen = 1'b1; Cfg_Port = CP'($urandom); Cfg_Addr = AA'($urandom); Cfg_Data = AD'($urandom);
      end
      @(posedge Clk); #1;
      Cfg_Wen = 1'b0;
    end
    if (abort_at >= 0) begin
      repeat (abort_at + 1) @(posedge Clk);
      #1;
      Start = 1'b0;
      if (use_rst) begin
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
      end
    end
    for (int i = 0; i < 100 && term_cnt == tc0; i++) @(negedge Clk);
    #1;
    checks++;
    if (term_cnt == tc0) begin
      errors++;
      $display("FAIL run_timeout: Busy still %0b after 100 cycles, required termination", Busy);
    end
    if (exp_done) begin
      repeat (3) @(posedge Clk);
      #1;
      chk("done_hold", {Done, Busy, Err, Port_En}, {1'b1, 1'b0, 1'b0, NP'(0)});
      Start = 1'b0;
      @(posedge Clk); #1;
      chk("done_ack", Done, 0);
    end else if (exp_err) begin
      repeat (3) @(posedge Clk);
      #1;
      chk("err_hold", {Err, Busy, Done, Port_En}, {1'b1, 1'b0, 1'b0, NP'(0)});
      Start = 1'b0;
      @(posedge Clk); #1;
      chk("err_sticky", Err, 1);
    end else begin
      chk("abort_done", {Done, Busy}, 0);
    end
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("acc_drained", acc_q.size(), 0);
    chk("term_drained", term_q.size(), 0);
    acc_q.delete();
    term_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("rst_done", Done, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err", Err, 0);
    chk("rst_items", Item_Cnt, 0);
    chk("rst_en", Port_En, 0);
    chk("rst_wen", Port_Wen, 0);
    chk("rst_addr", Port_Addr, 0);
    mon_en = 1;

    // Port 0 addresses 5 and 6 then kernel done; trailing words must never appear.
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < DEPTH; a++) mm[p][a] = '0;
    mm[0][0] = {1'b1, 1'b0, 3'b100, 13'd5};
    mm[0][1] = {1'b1, 1'b0, 3'b100, 13'd6};
    mm[0][2] = {1'b0, 1'b0, 3'b001, 13'd0};
    for (int a = 3; a < DEPTH; a++) mm[0][a] = {1'b1, 1'b1, 3'b100, DA'($urandom)};
    load_mem();
    run(-1, 0, 0);

    // Three work items, then a restart of the same schedule.
    fill_random();
    mm[0][0] = rw(3'b100);
    mm[0][1] = rw(3'b010);
    mm[0][2] = rw(3'b010);
    mm[0][3] = rw(3'b010);
    mm[0][4] = rw(3'b001);
    load_mem();
    run(-1, 0, 0);
    run(-1, 0, 0);

    // Reserved status at word 2.
    fill_random();
    mm[0][0] = rw(3'b100);
    mm[0][1] = rw(3'b100);
    mm[0][2] = rw(3'b011);
    load_mem();
    run(-1, 0, 0);

    // Schedule overrun.
    fill_random();
    sched0(DEPTH, 2);
    load_mem();
    run(-1, 0, 0);

    // Start dropped while word 3 is on the ports, then reset pulsed mid-run.
    fill_random();
    sched0(13, 0);
    load_mem();
    run(5, 0, 0);
    run(4, 1, 0);

    // Config writes during a run must not reach memory; the rerun uses the original contents.
    fill_random();
    sched0(13, 0);
    load_mem();
    run(-1, 0, 1);
    run(-1, 0, 0);

    repeat (20) begin
      fill_random();
      sched0($urandom_range(1, 13), $urandom_range(0, 2));
      load_mem();
      run(-1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_if_multi.md
Name: bram_if_multi

Overview:
- Parametrised successor to the CGRA BRAM interface.
- Sequences NUM_PORTS data-buffer BRAM ports from internal, host-loadable control-word memories (one per port), all indexed by a shared schedule counter.
- Decodes PE-array status from port 0's control word and runs a Start/Done/Busy handshake with the host.
- Adds error detection (reserved status, schedule overrun) and a work-item counter.

Parameters:
- NUM_PORTS, 2, number of data-buffer BRAM ports / control memories.
- SYS_DWIDTH, 32, data and address bus width.
- BYTE_LEN, 4, byte-enable bits per port.
- DBUF_AWIDTH, 13, data-buffer word-address width.
- ABUF_AWIDTH, 12, control-memory depth is 2^ABUF_AWIDTH.
- ABUF_DWIDTH, DBUF_AWIDTH+5, control-word width (derived; do not override).
- CPW, 1, Cfg_Port width; must satisfy 2^CPW >= NUM_PORTS.

Ports:
- Clk  in  1  single clock for everything.
- Rst  in  1  synchronous reset, active-high.
- Start  in  1  host level; rising edge launches a kernel; falling edge acknowledges Done.
- Done  out  1  kernel complete.
- Busy  out  1  schedule running.
- Err  out  1  sticky error.
- Item_Cnt  out  16  work-item completions in current kernel.
- Cfg_Wen  in  1  control-memory write strobe.
- Cfg_Port  in  CPW  target control memory.
- Cfg_Addr  in  ABUF_AWIDTH  control-memory address.
- Cfg_Data  in  ABUF_DWIDTH  control word.
- Port_En  out  NUM_PORTS  BRAM enables.
- Port_Wen  out  NUM_PORTS*BYTE_LEN  byte write enables.
- Port_Addr  out  NUM_PORTS*SYS_DWIDTH  BRAM addresses.
- Port_Data_To_Bram  out  NUM_PORTS*SYS_DWIDTH  write data, equal to Port_Data_From_CGRA.
- Port_Data_From_Bram  in  NUM_PORTS*SYS_DWIDTH  read data.
- Port_Data_To_CGRA  out  NUM_PORTS*SYS_DWIDTH  equal to Port_Data_From_Bram, combinational.
- Port_Data_From_CGRA  in  NUM_PORTS*SYS_DWIDTH  CGRA results.

Behaviour:
- Control-word fields, bit positions relative to DBUF_AWIDTH (D):
  - [D+4] En.
  - [D+3] Wen, replicated to all BYTE_LEN bits.
  - [D+2:D] status: 100 busy, 010 work-item done, 001 kernel done; all other codes reserved.
  - [D-1:0] word address.
- Reset: state IDLE; Done=0, Busy=0, Err=0, Item_Cnt=0, schedule counter Cnt=0, output registers 0 (all Port_En/Port_Wen/Port_Addr 0). Control-memory contents are not reset.
- Start edge detect: one register of Start, prev; rise = Start & !prev; fall = !Start & prev.
- Config writes: accepted only in IDLE; mem[Cfg_Port][Cfg_Addr] <= Cfg_Data. Ignored in other states; Cfg_Port >= NUM_PORTS is ignored.
- FSM states: IDLE, RUN, DONE, ERR.
  - IDLE, on rise: go to RUN; Cnt=0, Item_Cnt=0, Err=0.
  - RUN: Cnt increments each cycle. The memory read is registered (1 cycle), then the output register (1 cycle), so the word at address k drives the ports 2 cycles after Cnt=k. Busy=1.
  - RUN, status decoded from port 0's output register:
    - 010: Item_Cnt+1, saturating at 0xFFFF.
    - 001: next cycle go to DONE; Done=1, Busy=0.
    - Reserved code, once the first word is valid: go to ERR; Err=1.
    - Cnt reaches 2^ABUF_AWIDTH-1 without 001: go to ERR (overrun).
  - Start falls during RUN: abort to IDLE; Done stays 0.
  - Leaving RUN: output registers and pipeline-valid cleared the same cycle. The two prefetched words after the terminating word are never issued.
  - DONE: hold Done=1 until fall, then go to IDLE with Done=0. rise in DONE is ignored.
  - ERR: Err=1 (sticky). Exit only on fall, to IDLE; Err is cleared at the next rise.
- Outputs outside RUN: Port_En=0, Port_Wen=0, Port_Addr=0.
- Precedence when events coincide: Rst > fall > status 001 > reserved/overrun > 010.
- Reset mid-RUN: IDLE next cycle; all outputs at reset values.

Optional Feature:
- BRAMIF_BYTE_ADDR_EN defined: Port_Addr = {zeros, word address, log2(BYTE_LEN) zero bits}. This is byte granularity for the AXI BRAM controller in system builds.
- Not defined: Port_Addr = word address zero-extended to SYS_DWIDTH, for primitive-BRAM verification.

Test Plan:
- Load port 0 with {En=1, 100, addr 5}, {1, 100, 6}, {0, 001, 0}; raise Start. Required: Port_En[0]=1 with addresses 5 then 6 (byte mode 0x14, 0x18); Done=1 on the cycle after the 001 word; Port_En=0 thereafter; dropping Start gives Done=0 and IDLE.
- Schedule 100, 010, 010, 010, 001. Required: Item_Cnt=3 at Done; a re-start clears Item_Cnt to 0.
- Reserved status 011 at word 2. Required: Err=1, Busy=0, no further Port_En. Falling then rising Start clears Err.
- Memory filled with 100 and no 001 (ABUF_AWIDTH=4 build). Required: Err=1 when Cnt reaches 15.
- Start dropped mid-RUN at word 3, and Rst pulsed mid-RUN. Required: IDLE, Done=0, Port_En=0 next cycle. A Cfg write during RUN leaves memory unchanged (read back via a later run).
- NUM_PORTS=4, distinct schedules per port, Port_Data_From_CGRA[1]=0xDEADBEEF. Required: each port follows its own addresses; Port_Data_To_Bram[1]=0xDEADBEEF; status is taken from port 0 only.
